// File: rtl/instr_stream_loader_if.sv
// instr_stream_loader_if
//   Byte-stream input handshake plus instruction-memory write bus for the
//   program loader.
//   master : stream producer / memory observer (drives in_valid_i, in_data_i)
//   slave  : the loader (drives in_ready_o and the imem_* write bus)
//   Signals:
//     in_valid_i   - stream byte valid
//     in_data_i    - stream byte
//     in_ready_o   - loader can accept a byte
//     imem_we_o    - one-cycle write strobe per assembled word
//     imem_addr_o  - word address of the write
//     imem_wdata_o - 32-bit instruction word
interface instr_stream_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid_i;
    logic [7:0]        in_data_i;
    logic              in_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;

    modport master (
        output in_valid_i, in_data_i,
        input  in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
    );

    modport slave (
        input  in_valid_i, in_data_i,
        output in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
    );
endinterface

// File: rtl/instr_stream_loader.sv
// instr_stream_loader
//   Hardware program loader. Takes a little-endian byte stream
//   (2-byte word count, then count x 4-byte words, LSB first), writes each
//   word into instruction memory with a one-cycle strobe, then raises start_o
//   to launch the CPU.
//   Ports:
//     clk_i          - clock, rising edge
//     rst_i          - asynchronous active-low reset
//     bus            - stream handshake + imem write bus (slave side)
//     start_o        - CPU start, held until reset
//     busy_o         - loader is in HDR0/HDR1/DATA/START
//     err_o          - sticky: header count exceeded DEPTH
//     words_loaded_o - words written so far
module instr_stream_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    instr_stream_loader_if.slave bus,
    output logic                 start_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [15:0]          words_loaded_o
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_START,
        S_RUN,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [7:0]        r_cnt_lo;
    logic [15:0]       r_count;
    logic [1:0]        r_idx;
    logic [23:0]       r_asm;
    logic [ADDR_W-1:0] r_waddr;

    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_start;
    logic              r_busy;
    logic              r_err;
    logic [15:0]       r_words;

    logic              w_xfer;
    logic [15:0]       w_count;

    assign w_xfer  = bus.in_valid_i & r_ready;
    assign w_count = {bus.in_data_i, r_cnt_lo};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= S_HDR0;
            r_cnt_lo <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_asm    <= '0;
            r_waddr  <= '0;
            r_ready  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_words  <= '0;
        end else begin
            // Strobe is a single-cycle pulse; only a completing word re-arms it.
            r_we <= 1'b0;
            case (r_state)
                S_HDR0: begin
                    // ready/busy come up on the first edge out of reset
                    r_ready <= 1'b1;
                    r_busy  <= 1'b1;
                    if (w_xfer) begin
                        r_cnt_lo <= bus.in_data_i;
                        r_state  <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_xfer) begin
                        r_count <= w_count;
                        if ({1'b0, w_count} > DEPTH_L) begin
                            r_state <= S_ERR;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else if (w_count == 16'd0) begin
                            r_state <= S_START;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                            r_waddr <= '0;
                            r_idx   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_idx <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_asm[7:0]   <= bus.in_data_i;
                            2'd1: r_asm[15:8]  <= bus.in_data_i;
                            2'd2: r_asm[23:16] <= bus.in_data_i;
                            default: begin
                                // Fourth byte completes the word directly into
                                // the write register; no extra cycle.
                                r_we    <= 1'b1;
                                r_wdata <= {bus.in_data_i, r_asm};
                                r_addr  <= r_waddr;
                                r_waddr <= r_waddr + ADDR_W'(1);
                                r_words <= r_words + 16'd1;
                                if (r_words == r_count - 16'd1) begin
                                    r_state <= S_START;
                                    r_ready <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                S_START: begin
                    r_start <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_RUN;
                end
                S_RUN:   ;
                S_ERR:   ;
                default: r_state <= S_ERR;
            endcase
        end
    end

    assign bus.in_ready_o   = r_ready;
    assign bus.imem_we_o    = r_we;
    assign bus.imem_addr_o  = r_addr;
    assign bus.imem_wdata_o = r_wdata;
    assign start_o          = r_start;
    assign busy_o           = r_busy;
    assign err_o            = r_err;
    assign words_loaded_o   = r_words;

endmodule

// File: tb/tb_instr_stream_loader.sv
module tb_instr_stream_loader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_o, busy_o, err_o;
    logic [15:0] words_loaded_o;

    instr_stream_loader_if #(.ADDR_W(8)) bus();

    instr_stream_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .bus            (bus),
        .start_o        (start_o),
        .busy_o         (busy_o),
        .err_o          (err_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] sq[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_we_cyc;
    bit have_last = 0;
    bit gap_chk   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Scoreboard monitor: every write strobe pops one expected write.
    always @(negedge clk_i) begin
        if (bus.imem_we_o || start_o)
            chk("we_start_exclusive", {63'd0, bus.imem_we_o & start_o}, 64'd0);
        if (bus.imem_we_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we_addr", {56'd0, bus.imem_addr_o}, 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {56'd0, bus.imem_addr_o}, {56'd0, e.a});
                chk("wr_data", {32'd0, bus.imem_wdata_o}, {32'd0, e.d});
            end
            if (gap_chk && have_last)
                chk("we_gap", 64'(cyc - last_we_cyc), 64'd4);
            last_we_cyc = cyc;
            have_last   = 1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_idle);
        int n;
        n = (max_idle > 0) ? int'($urandom_range(max_idle, 0)) : 0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid_i = 1'b0;
            bus.in_data_i  = 8'($urandom);
            @(negedge clk_i);
        end
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = b;
        n = 0;
        while (!bus.in_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) chk("ready_timeout", {63'd0, bus.in_ready_o}, 64'd1);
        @(negedge clk_i);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic send_q(input int max_idle);
        while (sq.size() > 0) send_byte(sq.pop_front(), max_idle);
    endtask

    task automatic push_word(input logic [31:0] w);
        sq.push_back(w[7:0]);
        sq.push_back(w[15:8]);
        sq.push_back(w[23:16]);
        sq.push_back(w[31:24]);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i     = 1'b1;
        have_last = 0;
    endtask

    task automatic chk_q_empty(input string nm);
        repeat (3) @(negedge clk_i);
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = 8'h00;
        rst_i          = 1'b0;
        repeat (2) @(negedge clk_i);

        // Reset values
        chk("rst_ready", {63'd0, bus.in_ready_o}, 64'd0);
        chk("rst_we",    {63'd0, bus.imem_we_o}, 64'd0);
        chk("rst_addr",  {56'd0, bus.imem_addr_o}, 64'd0);
        chk("rst_wdata", {32'd0, bus.imem_wdata_o}, 64'd0);
        chk("rst_start", {63'd0, start_o}, 64'd0);
        chk("rst_busy",  {63'd0, busy_o}, 64'd0);
        chk("rst_err",   {63'd0, err_o}, 64'd0);
        chk("rst_words", {48'd0, words_loaded_o}, 64'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_ready", {63'd0, bus.in_ready_o}, 64'd1);
        chk("post_rst_busy",  {63'd0, busy_o}, 64'd1);

        // A: count=2, valid every cycle
        exp_q.push_back('{8'd0, 32'h0050_0013});
        exp_q.push_back('{8'd1, 32'h0010_0093});
        sq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        gap_chk = 1;
        send_q(0);
        chk("A_last_we", {63'd0, bus.imem_we_o}, 64'd1);
        @(negedge clk_i);
        gap_chk = 0;
        chk("A_start", {63'd0, start_o}, 64'd1);
        chk("A_ready", {63'd0, bus.in_ready_o}, 64'd0);
        chk("A_words", {48'd0, words_loaded_o}, 64'd2);
        chk("A_busy",  {63'd0, busy_o}, 64'd0);
        chk_q_empty("A_all_writes");

        // B: same stream with random idle gaps
        do_reset();
        exp_q.push_back('{8'd0, 32'h0050_0013});
        exp_q.push_back('{8'd1, 32'h0010_0093});
        sq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_q(3);
        chk("B_last_we", {63'd0, bus.imem_we_o}, 64'd1);
        chk("B_start_early", {63'd0, start_o}, 64'd0);
        @(negedge clk_i);
        chk("B_start", {63'd0, start_o}, 64'd1);
        chk("B_words", {48'd0, words_loaded_o}, 64'd2);
        chk_q_empty("B_all_writes");

        // C: header 00 00
        do_reset();
        sq = '{8'h00, 8'h00};
        send_q(0);
        chk("C_start_early", {63'd0, start_o}, 64'd0);
        @(negedge clk_i);
        chk("C_start", {63'd0, start_o}, 64'd1);
        repeat (3) @(negedge clk_i);
        chk("C_busy",  {63'd0, busy_o}, 64'd0);
        chk("C_words", {48'd0, words_loaded_o}, 64'd0);
        chk("C_start_held", {63'd0, start_o}, 64'd1);

        // D: header 01 01 -> count 257 > DEPTH
        do_reset();
        sq = '{8'h01, 8'h01};
        send_q(0);
        chk("D_err",   {63'd0, err_o}, 64'd1);
        chk("D_ready", {63'd0, bus.in_ready_o}, 64'd0);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 8'($urandom);
            @(negedge clk_i);
            chk("D_start_low", {63'd0, start_o}, 64'd0);
            chk("D_ready_low", {63'd0, bus.in_ready_o}, 64'd0);
            chk("D_err_held",  {63'd0, err_o}, 64'd1);
        end
        bus.in_valid_i = 1'b0;
        chk("D_words", {48'd0, words_loaded_o}, 64'd0);

        // E: reset mid-load, then a fresh count=1 stream
        do_reset();
        sq = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        send_q(0);
        #2 rst_i = 1'b0;
        #1;
        chk("E_rst_ready", {63'd0, bus.in_ready_o}, 64'd0);
        chk("E_rst_busy",  {63'd0, busy_o}, 64'd0);
        chk("E_rst_err",   {63'd0, err_o}, 64'd0);
        chk("E_rst_start", {63'd0, start_o}, 64'd0);
        chk("E_rst_we",    {63'd0, bus.imem_we_o}, 64'd0);
        chk("E_rst_words", {48'd0, words_loaded_o}, 64'd0);
        @(negedge clk_i);
        rst_i     = 1'b1;
        have_last = 0;
        exp_q.push_back('{8'd0, 32'h0000_0033});
        sq = '{8'h01, 8'h00};
        push_word(32'h0000_0033);
        send_q(0);
        @(negedge clk_i);
        chk("E_start", {63'd0, start_o}, 64'd1);
        chk("E_words", {48'd0, words_loaded_o}, 64'd1);
        chk_q_empty("E_all_writes");

        // F: count=DEPTH, word k = k
        do_reset();
        sq = '{8'h00, 8'h01};
        for (int k = 0; k < 256; k++) begin
            exp_q.push_back('{8'(k), 32'(k)});
            push_word(32'(k));
        end
        send_q(0);
        chk("F_words", {48'd0, words_loaded_o}, 64'd256);
        @(negedge clk_i);
        chk("F_start", {63'd0, start_o}, 64'd1);
        chk("F_err",   {63'd0, err_o}, 64'd0);
        chk_q_empty("F_all_writes");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
